// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   XLEN / INST_NOP / PC_STEP : machine constants used by fetch and its bench
//   fetch_state_e             : IDLE (one cycle after reset) -> RUN
//   fetch_entry_t             : one instruction-buffer entry {pc, inst}
//   word_align()              : clears the two low address bits
package fetch_unit_pkg;
  localparam int              XLEN     = 32;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

  typedef enum logic { ST_IDLE, ST_RUN } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, redirect from
// execute, and the {inst, pc} valid/ready handshake toward decode.
//   master : the fetch unit
//   slave  : the surrounding pipeline / memory (bench side)
interface fetch_unit_if;
  logic                           o_imem_req;
  logic [fetch_unit_pkg::XLEN-1:0] o_imem_raddr;
  logic                           i_imem_ready;
  logic                           i_imem_valid;
  logic [fetch_unit_pkg::XLEN-1:0] i_imem_rdata;
  logic                           i_redirect;
  logic [fetch_unit_pkg::XLEN-1:0] i_redirect_pc;
  logic                           o_inst_valid;
  logic [fetch_unit_pkg::XLEN-1:0] o_inst;
  logic [fetch_unit_pkg::XLEN-1:0] o_inst_pc;
  logic                           i_inst_ready;

  modport master (
    output o_imem_req, o_imem_raddr, o_inst_valid, o_inst, o_inst_pc,
    input  i_imem_ready, i_imem_valid, i_imem_rdata, i_redirect, i_redirect_pc, i_inst_ready
  );

  modport slave (
    input  o_imem_req, o_imem_raddr, o_inst_valid, o_inst, o_inst_pc,
    output i_imem_ready, i_imem_valid, i_imem_rdata, i_redirect, i_redirect_pc, i_inst_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer (power-of-two DEPTH).
//   push/wdata : write an entry (ignored when full unless popping too)
//   pop        : drop the head (ignored when empty)
//   flush      : empty the buffer; wins over push/pop
//   rdata      : head entry (valid when !empty)
//   full/empty/count : occupancy status, count is $clog2(DEPTH)+1 bits
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_nxt;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full buffer may still take a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)      count_nxt = count + CW'(1);
    else if (!do_push && do_pop) count_nxt = count - CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end.
//   clk, rst : clock and asynchronous active-low reset
//   bus      : fetch_unit_if.master -- imem request/response, redirect,
//              and the {inst, pc} handshake to decode
// Owns the PC, keeps at most FIFO_DEPTH requests in flight or buffered, tags
// responses with resp_pc, and throws away responses from before a redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_ADDR = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);
  localparam int            CW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]   CREDIT_MAX = (CW+1)'(FIFO_DEPTH);

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] pc, resp_pc, target;
  logic [CW-1:0]   outstanding, drop_cnt, occupancy;
  logic [CW:0]     credit_used;
  logic            req, accept, resp, push, pop, flush;
  logic            fifo_full, fifo_empty;
  fetch_entry_t    wr_entry, head;

  assign target   = word_align(bus.i_redirect_pc);
  assign resp     = bus.i_imem_valid;
  assign accept   = req & bus.i_imem_ready;
  assign flush    = bus.i_redirect;
  assign pop      = ~fifo_empty & bus.i_inst_ready & ~bus.i_redirect;
  assign push     = resp & (drop_cnt == '0) & ~bus.i_redirect;
  assign wr_entry = '{pc: resp_pc, inst: bus.i_imem_rdata};

  // Credit counts every slot already promised: requests in flight plus
  // buffered entries. An entry leaving this cycle frees its slot for a new
  // request, since that response cannot land before the next edge; this keeps
  // full throughput with a two-entry buffer.
  assign credit_used = {1'b0, outstanding} + {1'b0, occupancy} - (CW+1)'(pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    case (state)
      ST_IDLE: state_nxt = ST_RUN;
      ST_RUN:  req = ~bus.i_redirect & (credit_used < CREDIT_MAX);
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_ADDR;
      resp_pc     <= RESET_ADDR;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(resp);
      if (bus.i_redirect) begin
        pc      <= target;
        resp_pc <= target;
        // Drops are a subset of the outstanding requests, so after a redirect
        // every request still in flight (minus the one landing now) is stale.
        // This also keeps back-to-back redirects from double counting.
        drop_cnt <= outstanding - CW'(resp);
      end else begin
        if (accept) pc <= pc + PC_STEP;
        if (push)   resp_pc <= resp_pc + PC_STEP;
        if (resp && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wr_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occupancy)
  );

  assign bus.o_imem_req   = req;
  assign bus.o_imem_raddr = pc;
  assign bus.o_inst_valid = ~fifo_empty;
  // Empty buffer shows a NOP tagged with the next PC expected from memory.
  assign bus.o_inst       = fifo_empty ? INST_NOP : head.inst;
  assign bus.o_inst_pc    = fifo_empty ? resp_pc  : head.pc;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && fifo_full && !pop));
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(.RESET_ADDR(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat_min = 1;
  int lat_max = 1;

  logic [31:0] acc_addr[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_inst[$];
  int          got_cyc[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0] | 16'h0003};
  endfunction

  task automatic clear_obs();
    acc_addr.delete(); got_pc.delete(); got_inst.delete(); got_cyc.delete();
  endtask

  // One clock: sample just after inputs settle, cross the rising edge, then
  // update the memory model and drive its response at the falling edge.
  task automatic tick();
    logic acc, rsp, pop;
    #1;
    acc = bus.o_imem_req & bus.i_imem_ready;
    rsp = bus.i_imem_valid;
    pop = bus.o_inst_valid & bus.i_inst_ready & ~bus.i_redirect;
    if (pop) begin
      got_pc.push_back(bus.o_inst_pc); got_inst.push_back(bus.o_inst); got_cyc.push_back(cyc);
    end
    if (acc) begin
      acc_addr.push_back(bus.o_imem_raddr);
      pend_addr.push_back(bus.o_imem_raddr);
      pend_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
    end
    if (rsp) begin
      void'(pend_addr.pop_front()); void'(pend_due.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      bus.i_imem_valid = 1'b1; bus.i_imem_rdata = inst_of(pend_addr[0]);
    end else begin
      bus.i_imem_valid = 1'b0; bus.i_imem_rdata = 32'h0;
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.i_imem_valid = 1'b0; bus.i_imem_rdata = 32'h0;
    bus.i_redirect = 1'b0; bus.i_redirect_pc = 32'h0;
    bus.i_imem_ready = 1'b1; bus.i_inst_ready = 1'b1;
    pend_addr.delete(); pend_due.delete();
    @(negedge clk);
    rst = 1'b1;
    #1;
    cyc = 0;
    clear_obs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_imem_valid = 1'b0; bus.i_imem_rdata = 32'h0;
    bus.i_redirect = 1'b0; bus.i_redirect_pc = 32'h0;
    bus.i_imem_ready = 1'b1; bus.i_inst_ready = 1'b1;
    #1 rst = 1'b0;
    #2;
    checks++; if (bus.o_imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.o_imem_req); end
    checks++; if (bus.o_inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b want 0", bus.o_inst_valid); end
    checks++; if (bus.o_inst !== 32'h0000_0013) begin errors++; $display("FAIL reset_inst: got %h want 00000013", bus.o_inst); end
    checks++; if (bus.o_inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc: got %h want 0", bus.o_inst_pc); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    cyc = 0;
    clear_obs();
    tick();
    checks++; if (acc_addr.size() != 0) begin errors++; $display("FAIL idle_no_req: got %0d accepts want 0", acc_addr.size()); end
  endtask

  task automatic test_stream();
    do_reset();
    lat_min = 1; lat_max = 1;
    repeat (12) tick();
    checks++; if (acc_addr.size() < 8) begin errors++; $display("FAIL stream_acc_count: got %0d want >=8", acc_addr.size()); end
    for (int i = 0; i < 8 && i < acc_addr.size(); i++) begin
      checks++; if (acc_addr[i] !== 32'(4*i)) begin errors++; $display("FAIL stream_raddr[%0d]: got %h want %h", i, acc_addr[i], 32'(4*i)); end
    end
    checks++; if (got_pc.size() < 8) begin errors++; $display("FAIL stream_pop_count: got %0d want >=8", got_pc.size()); end
    for (int i = 0; i < 8 && i < got_pc.size(); i++) begin
      checks++; if (got_pc[i] !== 32'(4*i)) begin errors++; $display("FAIL stream_pc[%0d]: got %h want %h", i, got_pc[i], 32'(4*i)); end
      checks++; if (got_inst[i] !== inst_of(32'(4*i))) begin errors++; $display("FAIL stream_inst[%0d]: got %h want %h", i, got_inst[i], inst_of(32'(4*i))); end
      checks++; if (got_cyc[i] != 3 + i) begin errors++; $display("FAIL stream_cycle[%0d]: got %0d want %0d", i, got_cyc[i], 3 + i); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    lat_min = 1; lat_max = 1;
    bus.i_inst_ready = 1'b0;
    repeat (10) tick();
    checks++; if (acc_addr.size() != 2) begin errors++; $display("FAIL stall_accepts: got %0d want 2", acc_addr.size()); end
    checks++; if (bus.o_imem_req !== 1'b0) begin errors++; $display("FAIL stall_req: got %b want 0", bus.o_imem_req); end
    checks++; if (bus.o_inst_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b want 1", bus.o_inst_valid); end
    checks++; if (bus.o_inst_pc !== 32'h0) begin errors++; $display("FAIL stall_head_pc: got %h want 0", bus.o_inst_pc); end
    bus.i_inst_ready = 1'b1;
    repeat (10) tick();
    checks++; if (got_pc.size() < 8) begin errors++; $display("FAIL stall_pop_count: got %0d want >=8", got_pc.size()); end
    for (int i = 0; i < 8 && i < got_pc.size(); i++) begin
      checks++; if (got_pc[i] !== 32'(4*i)) begin errors++; $display("FAIL stall_pc[%0d]: got %h want %h", i, got_pc[i], 32'(4*i)); end
      checks++; if (got_cyc[i] != got_cyc[0] + i) begin errors++; $display("FAIL stall_gap[%0d]: got cycle %0d want %0d", i, got_cyc[i], got_cyc[0] + i); end
    end
  endtask

  task automatic test_redirect();
    int n;
    do_reset();
    lat_min = 2; lat_max = 2;
    n = 0;
    while (pend_addr.size() != 2 && n < 20) begin tick(); n++; end
    checks++; if (pend_addr.size() != 2) begin errors++; $display("FAIL redir_setup: got %0d outstanding want 2", pend_addr.size()); end
    bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h100;
    tick();
    bus.i_redirect = 1'b0;
    checks++; if (bus.o_inst_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: got valid %b want 0", bus.o_inst_valid); end
    clear_obs();
    repeat (15) tick();
    checks++; if (got_pc.size() < 4) begin errors++; $display("FAIL redir_pop_count: got %0d want >=4", got_pc.size()); end
    for (int i = 0; i < got_pc.size(); i++) begin
      checks++; if (got_pc[i] !== 32'h100 + 32'(4*i)) begin errors++; $display("FAIL redir_pc[%0d]: got %h want %h", i, got_pc[i], 32'h100 + 32'(4*i)); end
      checks++; if (got_inst[i] !== inst_of(got_pc[i])) begin errors++; $display("FAIL redir_inst[%0d]: got %h want %h", i, got_inst[i], inst_of(got_pc[i])); end
    end
  endtask

  task automatic test_redirect_pop();
    int n, exp_drop;
    do_reset();
    lat_min = 2; lat_max = 2;
    repeat (6) tick();
    n = 0;
    while (!(bus.o_inst_valid && bus.i_imem_valid) && n < 30) begin tick(); n++; end
    checks++; if (!(bus.o_inst_valid && bus.i_imem_valid)) begin errors++; $display("FAIL rpop_setup: got valid %b resp %b want 1 1", bus.o_inst_valid, bus.i_imem_valid); end
    exp_drop = pend_addr.size() - 1;
    bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h340;
    tick();
    bus.i_redirect = 1'b0;
    checks++; if (bus.o_inst_valid !== 1'b0) begin errors++; $display("FAIL rpop_empty: got valid %b want 0", bus.o_inst_valid); end
    checks++; if (int'(dut.drop_cnt) != exp_drop) begin errors++; $display("FAIL rpop_drop_cnt: got %0d want %0d", dut.drop_cnt, exp_drop); end
    clear_obs();
    repeat (12) tick();
    checks++; if (got_pc.size() < 3) begin errors++; $display("FAIL rpop_pop_count: got %0d want >=3", got_pc.size()); end
    for (int i = 0; i < got_pc.size(); i++) begin
      checks++; if (got_pc[i] !== 32'h340 + 32'(4*i)) begin errors++; $display("FAIL rpop_pc[%0d]: got %h want %h", i, got_pc[i], 32'h340 + 32'(4*i)); end
    end
  endtask

  task automatic test_imem_stall();
    int n, acc_before;
    logic [31:0] ra0;
    do_reset();
    lat_min = 1; lat_max = 4;
    repeat (4) tick();
    n = 0;
    while (bus.o_imem_req !== 1'b1 && n < 10) begin tick(); n++; end
    ra0 = bus.o_imem_raddr;
    acc_before = acc_addr.size();
    bus.i_imem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (bus.o_imem_req !== 1'b1) begin errors++; $display("FAIL hold_req[%0d]: got %b want 1", k, bus.o_imem_req); end
      checks++; if (bus.o_imem_raddr !== ra0) begin errors++; $display("FAIL hold_raddr[%0d]: got %h want %h", k, bus.o_imem_raddr, ra0); end
    end
    checks++; if (acc_addr.size() != acc_before) begin errors++; $display("FAIL hold_no_accept: got %0d want %0d", acc_addr.size(), acc_before); end
    bus.i_imem_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      bus.i_inst_ready = 1'($urandom_range(1, 0));
      tick();
    end
    bus.i_inst_ready = 1'b1;
    repeat (12) tick();
    for (int i = 0; i < acc_addr.size(); i++) begin
      checks++; if (acc_addr[i] !== 32'(4*i)) begin errors++; $display("FAIL lat_raddr[%0d]: got %h want %h", i, acc_addr[i], 32'(4*i)); end
    end
    checks++; if (got_pc.size() < 10) begin errors++; $display("FAIL lat_pop_count: got %0d want >=10", got_pc.size()); end
    for (int i = 0; i < got_pc.size(); i++) begin
      checks++; if (got_pc[i] !== 32'(4*i)) begin errors++; $display("FAIL lat_pc[%0d]: got %h want %h", i, got_pc[i], 32'(4*i)); end
      checks++; if (got_inst[i] !== inst_of(32'(4*i))) begin errors++; $display("FAIL lat_inst[%0d]: got %h want %h", i, got_inst[i], inst_of(32'(4*i))); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    lat_min = 1; lat_max = 1;
    repeat (8) tick();
    checks++; if (bus.o_inst_valid !== 1'b1) begin errors++; $display("FAIL ares_burst: got valid %b want 1", bus.o_inst_valid); end
    rst = 1'b0;
    bus.i_imem_valid = 1'b0;
    pend_addr.delete(); pend_due.delete();
    #1;
    checks++; if (bus.o_imem_req !== 1'b0) begin errors++; $display("FAIL ares_req: got %b want 0", bus.o_imem_req); end
    checks++; if (bus.o_inst_valid !== 1'b0) begin errors++; $display("FAIL ares_valid: got %b want 0", bus.o_inst_valid); end
    checks++; if (bus.o_inst !== 32'h0000_0013) begin errors++; $display("FAIL ares_inst: got %h want 00000013", bus.o_inst); end
    checks++; if (bus.o_inst_pc !== 32'h0) begin errors++; $display("FAIL ares_pc: got %h want 0", bus.o_inst_pc); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    cyc = 0;
    clear_obs();
    tick();
    checks++; if (acc_addr.size() != 0) begin errors++; $display("FAIL ares_idle: got %0d accepts want 0", acc_addr.size()); end
    tick();
    checks++; if (acc_addr.size() != 1 || acc_addr[0] !== 32'h0) begin errors++; $display("FAIL ares_restart: got %0d accepts first %h want 1 at 0", acc_addr.size(), (acc_addr.size() > 0) ? acc_addr[0] : 32'hFFFF_FFFF); end
    bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h203;
    tick();
    bus.i_redirect = 1'b0;
    clear_obs();
    repeat (8) tick();
    checks++; if (acc_addr.size() == 0 || acc_addr[0] !== 32'h200) begin errors++; $display("FAIL align_raddr: got %h want 00000200", (acc_addr.size() > 0) ? acc_addr[0] : 32'hFFFF_FFFF); end
    checks++; if (got_pc.size() == 0 || got_pc[0] !== 32'h200) begin errors++; $display("FAIL align_pc: got %h want 00000200", (got_pc.size() > 0) ? got_pc[0] : 32'hFFFF_FFFF); end
    checks++; if (got_inst.size() == 0 || got_inst[0] !== inst_of(32'h200)) begin errors++; $display("FAIL align_inst: got %h want %h", (got_inst.size() > 0) ? got_inst[0] : 32'hFFFF_FFFF, inst_of(32'h200)); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_pop();
    test_imem_stall();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule
